// File: rtl/debug_mem_dumper_pkg.sv
// Shared definitions for the debug memory dumper: FSM state encoding and a
// width helper used to size the byte counter.
package debug_mem_dumper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_e;

  // Bits needed to index 'value' items; never less than one so a
  // single-byte slot still has a real counter register.
  function automatic int clog2Min1(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/debug_mem_dumper_byte_selector.sv
// Pure indexing: picks one byte out of a flattened memory image, given a
// word index and a byte index where byte 0 is the most-significant byte.
module debug_mem_dumper_byte_selector
  import debug_mem_dumper_pkg::*;
#(
  parameter int ADDR_SIZE = 5,
  parameter int SLOT_SIZE = 32,
  parameter int BYTE_SIZE = 8,
  localparam int NUM_SLOTS = 2 ** ADDR_SIZE,
  localparam int BYTES_PER_SLOT = SLOT_SIZE / BYTE_SIZE,
  localparam int BYTE_IDX_W = clog2Min1(BYTES_PER_SLOT)
) (
  input  logic [NUM_SLOTS*SLOT_SIZE-1:0] bus_i,
  input  logic [ADDR_SIZE-1:0]           word_i,
  input  logic [BYTE_IDX_W-1:0]          byte_i,
  output logic [BYTE_SIZE-1:0]           data_o
);

  logic [SLOT_SIZE-1:0] slots [NUM_SLOTS];
  logic [BYTE_SIZE-1:0] lanes [BYTES_PER_SLOT];
  logic [SLOT_SIZE-1:0] slotSel;

  // Unpack the flat bus into one entry per memory slot.
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : gSlot
    assign slots[k] = bus_i[k*SLOT_SIZE +: SLOT_SIZE];
  end

  assign slotSel = slots[word_i];

  // Lane 0 is the top byte of the slot so the stream comes out MSB first.
  for (genvar j = 0; j < BYTES_PER_SLOT; j++) begin : gLane
    assign lanes[j] = slotSel[SLOT_SIZE-1-j*BYTE_SIZE -: BYTE_SIZE];
  end

  assign data_o = lanes[byte_i];

endmodule

// File: rtl/debug_mem_dumper.sv
// Snapshots the data memory debug bus on a start request and streams it out
// byte by byte (word 0 first, MSB first) over a valid/ready handshake toward
// the UART transmitter.
module debug_mem_dumper
  import debug_mem_dumper_pkg::*;
#(
  parameter int ADDR_SIZE = 5,
  parameter int SLOT_SIZE = 32,
  parameter int BYTE_SIZE = 8
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_start,
  input  logic [(2**ADDR_SIZE)*SLOT_SIZE-1:0] i_bus_debug,
  output logic [BYTE_SIZE-1:0]                o_data,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic                                o_busy,
  output logic                                o_done
);

  localparam int BUS_W = (2 ** ADDR_SIZE) * SLOT_SIZE;
  localparam int BYTES_PER_SLOT = SLOT_SIZE / BYTE_SIZE;
  localparam int BYTE_IDX_W = clog2Min1(BYTES_PER_SLOT);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_SLOT - 1);
  localparam logic [ADDR_SIZE-1:0] LAST_WORD = '1;

  state_e                state_q, state_d;
  logic [ADDR_SIZE-1:0]  wordCnt_q, wordCnt_d;
  logic [BYTE_IDX_W-1:0] byteCnt_q, byteCnt_d;
  logic [BUS_W-1:0]      snapshot_q;
  logic [BYTE_SIZE-1:0]  data_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;

  logic [BUS_W-1:0]      selBus;
  logic [BYTE_SIZE-1:0]  selByte;
  logic                  lastByte;
  logic                  terminal;

  assign lastByte = (byteCnt_q == LAST_BYTE);
  assign terminal = lastByte && (wordCnt_q == LAST_WORD);

  // The byte presented after the coming edge is looked up with the
  // next-state counters; on the start edge the snapshot is not loaded yet,
  // so the live bus is indexed instead.
  assign selBus = (state_q == IDLE) ? i_bus_debug : snapshot_q;

  debug_mem_dumper_byte_selector #(
    .ADDR_SIZE (ADDR_SIZE),
    .SLOT_SIZE (SLOT_SIZE),
    .BYTE_SIZE (BYTE_SIZE)
  ) uSelector (
    .bus_i  (selBus),
    .word_i (wordCnt_d),
    .byte_i (byteCnt_d),
    .data_o (selByte)
  );

  // Next-state and counter advance: counters move only on a handshake and
  // the byte counter rolling over bumps the word counter.
  always_comb begin
    state_d   = state_q;
    wordCnt_d = wordCnt_q;
    byteCnt_d = byteCnt_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = SEND;
          wordCnt_d = '0;
          byteCnt_d = '0;
        end
      end
      SEND: begin
        if (i_ready) begin
          if (terminal) begin
            state_d = DONE;
          end
          if (lastByte) begin
            byteCnt_d = '0;
            wordCnt_d = wordCnt_q + 1'b1;
          end else begin
            byteCnt_d = byteCnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, snapshot and registered handshake outputs. Outputs are
  // set on the transition into a state so they line up with that state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      wordCnt_q  <= '0;
      byteCnt_q  <= '0;
      snapshot_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wordCnt_q <= wordCnt_d;
      byteCnt_q <= byteCnt_d;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            snapshot_q <= i_bus_debug;
            data_q     <= selByte;
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        SEND: begin
          if (i_ready) begin
            if (terminal) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              data_q <= selByte;
            end
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_debug_mem_dumper.sv
// Scoreboard bench for debug_mem_dumper: the stimulus side pushes the bytes
// a dump must produce, and a monitor pops and compares on every handshake.
module tb_debug_mem_dumper;

  localparam int ADDR_SIZE   = 5;
  localparam int SLOT_SIZE   = 32;
  localparam int BYTE_SIZE   = 8;
  localparam int NUM_SLOTS   = 2 ** ADDR_SIZE;
  localparam int TOTAL_BYTES = NUM_SLOTS * (SLOT_SIZE / BYTE_SIZE);

  logic clk = 1'b0;
  logic i_reset;
  logic i_start;
  logic i_ready;
  logic [NUM_SLOTS*SLOT_SIZE-1:0] busDebug;
  logic [BYTE_SIZE-1:0] o_data;
  logic o_valid;
  logic o_busy;
  logic o_done;

  logic [SLOT_SIZE-1:0] mem [NUM_SLOTS];

  logic [7:0] expQ [$];
  int checks = 0;
  int fails = 0;
  int hsCount = 0;
  int doneCount = 0;
  int cycleCount = 0;
  int firstHs = -1;
  int lastHs = -1;
  logic prevStall = 1'b0;
  logic prevHs = 1'b0;
  logic [7:0] prevData = '0;
  logic randReady = 1'b0;

  always #5 clk = ~clk;

  // Flatten the bench memory image the same way data_memory presents it.
  always_comb begin
    busDebug = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      busDebug[k*SLOT_SIZE +: SLOT_SIZE] = mem[k];
    end
  end

  debug_mem_dumper #(
    .ADDR_SIZE (ADDR_SIZE),
    .SLOT_SIZE (SLOT_SIZE),
    .BYTE_SIZE (BYTE_SIZE)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_bus_debug (busDebug),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: samples at the falling edge, compares every accepted byte
  // against the scoreboard, and watches hold-stability and the done pulse.
  always @(negedge clk) begin
    cycleCount++;
    if (i_reset) begin
      prevStall = 1'b0;
      prevHs    = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("hold valid", 32'(o_valid), 32'd1);
        checkOutput("hold data", 32'(o_data), 32'(prevData));
      end
      if (o_done) begin
        doneCount++;
        checkOutput("done follows last byte", 32'(prevHs), 32'd1);
        checkOutput("queue empty at done", expQ.size(), 32'd0);
        checkOutput("busy in done", 32'(o_busy), 32'd1);
        checkOutput("valid low in done", 32'(o_valid), 32'd0);
      end
      if (o_valid) begin
        checkOutput("busy while valid", 32'(o_busy), 32'd1);
      end
      prevHs = 1'b0;
      if (o_valid && i_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected byte", 32'(o_data), 32'hFFFF_FFFF);
        end else begin
          checkOutput("stream byte", 32'(o_data), 32'(expQ.pop_front()));
        end
        hsCount++;
        if (firstHs < 0) firstHs = cycleCount;
        lastHs = cycleCount;
        prevHs = 1'b1;
      end
      prevStall = o_valid && !i_ready;
      prevData  = o_data;
    end
  end

  // Random backpressure driver, active only while randReady is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) i_ready = 1'($urandom_range(0, 1));
    end
  end

  // Global time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pulseStart();
    @(posedge clk);
    #1;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  // Queue the full expected byte stream for the current memory image, MSB
  // byte of each word first, then request the dump.
  task automatic applyStimulus();
    for (int w = 0; w < NUM_SLOTS; w++) begin
      for (int b = 0; b < 4; b++) begin
        expQ.push_back(8'(mem[w] >> (24 - 8 * b)));
      end
    end
    pulseStart();
  endtask

  task automatic waitHandshakes(input int target, input int budget);
    int n;
    n = 0;
    while (hsCount < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("handshakes reached", 32'(hsCount >= target), 32'd1);
  endtask

  task automatic waitDone(input int target, input int budget);
    int n;
    n = 0;
    while (doneCount < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("dump completes", 32'(doneCount >= target), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("single done pulse", doneCount, target);
    checkOutput("all bytes emitted", expQ.size(), 32'd0);
    checkOutput("idle after dump", 32'(o_busy), 32'd0);
  endtask

  initial begin
    int base;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < NUM_SLOTS; k++) mem[k] = 32'hA500_0000 | k;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset valid", 32'(o_valid), 32'd0);
    checkOutput("reset busy", 32'(o_busy), 32'd0);
    checkOutput("reset done", 32'(o_done), 32'd0);
    checkOutput("reset data", 32'(o_data), 32'd0);
    i_reset = 1'b0;

    // Reset mid-dump: abort after five accepted bytes, no done pulse.
    base = doneCount;
    applyStimulus();
    waitHandshakes(hsCount + 5, 50);
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    checkOutput("abort valid", 32'(o_valid), 32'd0);
    checkOutput("abort busy", 32'(o_busy), 32'd0);
    expQ.delete();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no done after abort", doneCount, base);

    // Basic dump with ready tied high: 128 bytes in consecutive cycles.
    firstHs = -1;
    applyStimulus();
    waitDone(doneCount + 1, 400);
    checkOutput("back-to-back span", lastHs - firstHs, TOTAL_BYTES - 1);

    // Backpressure: same stream with random ready.
    randReady = 1'b1;
    applyStimulus();
    waitDone(doneCount + 1, 2000);
    randReady = 1'b0;
    i_ready = 1'b1;

    // Snapshot isolation: slot 3 changes two cycles after the start edge.
    mem[3] = 32'h1234_5678;
    applyStimulus();
    @(posedge clk);
    @(posedge clk);
    #1;
    mem[3] = 32'hDEAD_BEEF;
    waitDone(doneCount + 1, 400);
    mem[3] = 32'hA500_0003;

    // Start while busy: a second request at byte 40 must be ignored.
    applyStimulus();
    waitHandshakes(hsCount + 40, 200);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    waitDone(doneCount + 1, 400);

    // Integration image: ten written words, the rest zero.
    for (int k = 0; k < NUM_SLOTS; k++) mem[k] = '0;
    mem[0] = 32'h3C1A_77E2;
    mem[1] = 32'h0000_00FF;
    mem[2] = 32'h8001_4020;
    mem[3] = 32'hFFFF_FFFF;
    mem[4] = 32'h1357_9BDF;
    mem[5] = 32'h2468_ACE0;
    mem[6] = 32'h7F00_0001;
    mem[7] = 32'hC0DE_CAFE;
    mem[8] = 32'h0102_0304;
    mem[9] = 32'h5A5A_A5A5;
    applyStimulus();
    waitDone(doneCount + 1, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/debug_mem_dumper.md
Name: debug_mem_dumper

Overview:
- Reads the data memory's flattened debug bus and streams its contents out as a byte sequence, for the host-side debugger link (UART transmitter input).
- On a start request it snapshots the entire bus. It then emits every slot, word 0 first and most-significant byte first, using a valid/ready handshake.
- It sits between data_memory.o_bus_debug and the UART TX front end.

Parameters:
- ADDR_SIZE, 5, memory address width; number of slots = 2**ADDR_SIZE.
- SLOT_SIZE, 32, bits per memory slot; must be a multiple of BYTE_SIZE.
- BYTE_SIZE, 8, width of each output transfer.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  request a dump; sampled only in IDLE.
- i_bus_debug  in  2**ADDR_SIZE*SLOT_SIZE  flattened memory contents; slot k is at [k*SLOT_SIZE +: SLOT_SIZE].
- o_data  out  BYTE_SIZE  current output byte.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  sink accepts o_data this cycle.
- o_busy  out  1  dump in progress (SEND or DONE state).
- o_done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (synchronous, active-high) forces state IDLE and clears o_data, o_valid, o_busy, o_done, the word counter and the byte counter to 0.
- Reset asserted mid-dump aborts the dump. No o_done is produced. The next dump starts from word 0.
- Byte order:
  - BYTES_PER_SLOT = SLOT_SIZE/BYTE_SIZE (4 by default).
  - TOTAL_BYTES = 2**ADDR_SIZE * BYTES_PER_SLOT (128 by default).
  - Byte b of word w is snapshot[w*SLOT_SIZE + SLOT_SIZE-1 - b*BYTE_SIZE -: BYTE_SIZE], so b=0 is the MSB byte.
- Counters:
  - Word counter is ADDR_SIZE bits.
  - Byte counter is clog2(BYTES_PER_SLOT) bits, with a minimum of 1.
  - Both wrap naturally. Terminal condition: word = 2**ADDR_SIZE-1 and byte = BYTES_PER_SLOT-1.
- State IDLE:
  - o_valid=0, o_busy=0.
  - Edge with i_start=1: copy i_bus_debug into the internal snapshot register, clear both counters, go to SEND.
  - o_valid=1 and o_data = word0 byte0 in the first cycle after that edge.
- State SEND:
  - o_valid=1, o_busy=1, and o_data is driven from the snapshot and counters.
  - A handshake occurs on an edge with o_valid && i_ready. It advances the byte counter. When the byte counter wraps, it clears to 0 and the word counter increments.
  - With i_ready=0, o_data and o_valid hold stable for any number of cycles, and o_valid never drops without a handshake.
  - Handshake on the terminal byte: go to DONE.
  - Back-to-back i_ready=1 gives one byte per cycle. A full dump then takes TOTAL_BYTES cycles in SEND.
- State DONE:
  - Lasts exactly one cycle: o_done=1, o_valid=0, o_busy=1. Then go to IDLE.
- i_start:
  - Ignored in SEND and DONE; no queuing.
  - i_start held high continuously gives back-to-back dumps separated by the DONE cycle and one IDLE cycle.
- Snapshot consistency: changes on i_bus_debug after the start edge do not affect the dump in progress.
- o_data in IDLE and DONE holds its last value. It is don't-care for the sink.

Decomposition:
- Shared package / header: state encoding constants (IDLE=2'b00, SEND=2'b01, DONE=2'b10) and a clog2 helper function.
- Sub-module byte_selector: purely indexing, selects the byte by word and byte index from the snapshot. The FSM, counters and snapshot register stay in the top module.

Test Plan:
- Reset mid-dump: start, accept 5 bytes, assert i_reset for 1 cycle.
  - o_valid=0, o_busy=0, no o_done.
  - The next start re-emits from word0 byte0.
- Basic dump:
  - Stimulus: i_bus_debug slot k = 32'hA5000000 | k, i_ready tied 1, pulse i_start.
  - Required: 128 bytes in 128 consecutive cycles. The sequence is A5,00,00,00, A5,00,00,01, … , A5,00,00,1F. o_done pulses once, the cycle after the last byte.
- Backpressure:
  - Stimulus: i_ready random, 50% duty, constrained $urandom.
  - Required: o_data stable and o_valid held while i_ready=0. Sequence identical to the basic dump, with no byte lost or repeated.
- Snapshot isolation: start with slot 3 = 32'h12345678, then 2 cycles later change slot 3 to 32'hDEADBEEF.
  - Bytes 12..15 are 12,34,56,78.
- Start while busy: pulse i_start at byte 40 of a dump.
  - Required: no restart, counters unaffected. Exactly 128 bytes and one o_done.
- Integration: data_memory with the same write pattern as its own bench (10 random words to addresses 0..9, rest 0), its o_bus_debug wired to i_bus_debug.
  - Required: the dumped bytes for words 0..9 match the written values MSB first. Words 10..31 dump as 00.
